acq: RTL



---
 rtl/acq_pkg.sv | 21 ++
 rtl/acq_if.sv | 27 ++
 rtl/acq_buf.sv | 28 ++
 rtl/acq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared types and default widths for the acquisition channel
package acq_pkg;

  localparam int TN_DEF  = 1;
  localparam int CWM_DEF = 14;
  localparam int CW_DEF  = 32;
  localparam int DW      = 16;
  localparam int BW      = 32;
  localparam int AW      = 32;

  typedef logic [DW-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARM,
    PST,
    DONE
  } acq_state_t;

endpackage

// File: rtl/acq_if.sv
// rtl/acq_if.sv - sample stream and system bus interfaces
interface axi4_stream_if;
  import acq_pkg::*;

  sample_t tdata;
  logic    tvalid;
  logic    tready;
  logic    tlast;

  modport s (output tdata, tvalid, tlast, input tready);
  modport d (input tdata, tvalid, tlast, output tready);
endinterface

interface sys_bus_if;
  import acq_pkg::*;

  logic [AW-1:0] addr;
  logic [BW-1:0] wdata;
  logic [BW-1:0] rdata;
  logic          wen;
  logic          ren;
  logic          ack;
  logic          err;

  modport m (output addr, wdata, wen, ren, input rdata, ack, err);
  modport s (input addr, wdata, wen, ren, output rdata, ack, err);
endinterface

// File: rtl/acq_buf.sv
// rtl/acq_buf.sv - sample ring buffer, one 16-bit write port and one 32-bit read port
module acq_buf
  import acq_pkg::*;
#(
  parameter int CWM = CWM_DEF
) (
  input  logic           clk,
  input  logic           we,
  input  logic [CWM-1:0] waddr,
  input  sample_t        wdata,
  input  logic           re,
  input  logic [CWM-2:0] raddr,
  output logic [BW-1:0]  rdata
);

  localparam int DEPTH = 2 ** (CWM - 1);

  // Even and odd samples live in separate banks so one bus word reads both halves at once.
  sample_t mem_lo [DEPTH];
  sample_t mem_hi [DEPTH];

  always_ff @(posedge clk) begin
    if (we && !waddr[0]) mem_lo[waddr[CWM-1:1]] <= wdata;
    if (we &&  waddr[0]) mem_hi[waddr[CWM-1:1]] <= wdata;
    if (re) rdata <= {mem_hi[raddr], mem_lo[raddr]};
  end

endmodule

// File: rtl/acq.sv
// rtl/acq.sv - stream acquisition channel: ring buffer capture with pre/post trigger FSM
module acq
  import acq_pkg::*;
#(
  parameter int TN  = TN_DEF,
  parameter int CWM = CWM_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  axi4_stream_if.d       sti,
  input  logic           ctl_rst,
  input  logic           ctl_str,
  input  logic [TN-1:0]  trg_i,
  input  logic [TN-1:0]  cfg_trg,
  input  logic [CW-1:0]  cfg_pre,
  input  logic [CW-1:0]  cfg_pst,
  output logic           trg_o,
  output logic           irq_trg,
  output logic           irq_stp,
  output logic           sts_run,
  output logic [CW-1:0]  sts_pre,
  output logic [CW-1:0]  sts_pst,
  output logic [CWM-1:0] sts_ptr,
  output logic           sts_lst,
  sys_bus_if.s           bus
);

  acq_state_t     state, state_n;
  logic [CWM-1:0] wptr, wptr_n, ptr_n;
  logic [CW-1:0]  pre_n, pst_n;
  logic           lst_n, wr_en, acc, trg, stp_n;

  assign sti.tready = 1'b1;
  assign sts_run    = (state == PRE) || (state == ARM) || (state == PST);
  assign acc        = sti.tvalid && sts_run;
  assign trg        = |(trg_i & cfg_trg);

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    pre_n   = sts_pre;
    pst_n   = sts_pst;
    ptr_n   = sts_ptr;
    lst_n   = sts_lst;
    irq_trg = 1'b0;
    wr_en   = acc;
    if (acc) wptr_n = wptr + CWM'(1);

    case (state)
      IDLE, DONE: begin
        if (ctl_str) begin
          wptr_n  = '0;
          pre_n   = '0;
          pst_n   = '0;
          lst_n   = 1'b0;
          state_n = (cfg_pre == '0) ? ARM : PRE;
        end
      end
      PRE: begin
        if (acc) begin
          pre_n = sts_pre + CW'(1);
          if (sti.tlast) begin
            state_n = DONE;
            lst_n   = 1'b1;
          end else if (pre_n == cfg_pre) begin
            state_n = ARM;
          end
        end
      end
      ARM: begin
        // TLAST outranks a trigger arriving in the same cycle.
        if (acc && sti.tlast) begin
          state_n = DONE;
          lst_n   = 1'b1;
        end else if (trg) begin
          irq_trg = 1'b1;
          ptr_n   = wptr_n;
          state_n = (cfg_pst == '0) ? DONE : PST;
        end
      end
      PST: begin
        if (acc) begin
          pst_n = sts_pst + CW'(1);
          if (sti.tlast) begin
            state_n = DONE;
            lst_n   = 1'b1;
          end else if (pst_n == cfg_pst) begin
            state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (ctl_rst) begin
      state_n = IDLE;
      wptr_n  = '0;
      pre_n   = '0;
      pst_n   = '0;
      ptr_n   = '0;
      lst_n   = 1'b0;
      irq_trg = 1'b0;
      wr_en   = 1'b0;
    end
  end

  assign stp_n = (state_n == DONE) && (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wptr    <= '0;
      sts_pre <= '0;
      sts_pst <= '0;
      sts_ptr <= '0;
      sts_lst <= 1'b0;
      trg_o   <= 1'b0;
      irq_stp <= 1'b0;
      bus.ack <= 1'b0;
    end else begin
      state   <= state_n;
      wptr    <= wptr_n;
      sts_pre <= pre_n;
      sts_pst <= pst_n;
      sts_ptr <= ptr_n;
      sts_lst <= lst_n;
      trg_o   <= irq_trg;
      irq_stp <= stp_n;
      bus.ack <= bus.ren | bus.wen;
    end
  end

  assign bus.err = 1'b0;

  logic unused_bus;
  assign unused_bus = ^{bus.wdata, bus.addr[AW-1:CWM+1], bus.addr[1:0]};

  acq_buf #(.CWM(CWM)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (sti.tdata),
    .re    (bus.ren),
    .raddr (bus.addr[CWM:2]),
    .rdata (bus.rdata)
  );

endmodule
